// File: rtl/beat_pkg.sv
// Shared constants, types and helpers for the beat-tracking comb filter bank.
package beat_pkg;

    localparam int unsigned NUM_BANDS  = 5;
    localparam int unsigned NUM_TEMPOS = 6;
    localparam int unsigned NUM_CHANS  = NUM_BANDS * NUM_TEMPOS;

    localparam int unsigned TEMPO_BPM [NUM_TEMPOS] = '{60, 90, 120, 180, 210, 240};

    localparam int unsigned D60_DEF  = 50;
    localparam int unsigned D90_DEF  = 33;
    localparam int unsigned D120_DEF = 25;
    localparam int unsigned D180_DEF = 17;
    localparam int unsigned D210_DEF = 14;
    localparam int unsigned D240_DEF = 12;

    // Start of each tempo's ring inside a band region; running sum of the delays.
    localparam int unsigned TEMPO_OFFSET [NUM_TEMPOS] = '{0, 50, 83, 108, 125, 139};
    localparam int unsigned BANK_STRIDE = 151;
    localparam int unsigned MEM_WORDS   = NUM_BANDS * BANK_STRIDE;

    typedef enum logic [1:0] {StClear, StIdle, StRun, StDone} state_e;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127) begin
            return 8'sh7f;
        end else if (v < -10'sd128) begin
            return 8'sh80;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/comb_delay_ram.sv
// Simple dual-port delay memory: one write port, one registered read port.
module comb_delay_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/comb_bank.sv
// Time-multiplexed bank of 30 feedback comb filters (5 bands x 6 tempos)
// sharing one delay memory; results are presented together with a ready strobe.
module comb_bank
    import beat_pkg::*;
#(
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned D60         = D60_DEF,
    parameter int unsigned D90         = D90_DEF,
    parameter int unsigned D120        = D120_DEF,
    parameter int unsigned D180        = D180_DEF,
    parameter int unsigned D210        = D210_DEF,
    parameter int unsigned D240        = D240_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_sample_valid,
    input  logic signed [7:0] i_band0,
    input  logic signed [7:0] i_band1,
    input  logic signed [7:0] i_band2,
    input  logic signed [7:0] i_band3,
    input  logic signed [7:0] i_band4,
    output logic signed [7:0] o_comb00, o_comb01, o_comb02, o_comb03, o_comb04, o_comb05,
    output logic signed [7:0] o_comb10, o_comb11, o_comb12, o_comb13, o_comb14, o_comb15,
    output logic signed [7:0] o_comb20, o_comb21, o_comb22, o_comb23, o_comb24, o_comb25,
    output logic signed [7:0] o_comb30, o_comb31, o_comb32, o_comb33, o_comb34, o_comb35,
    output logic signed [7:0] o_comb40, o_comb41, o_comb42, o_comb43, o_comb44, o_comb45,
    output logic              o_ready,
    output logic              o_overrun
);

    localparam int unsigned DLY [NUM_TEMPOS] = '{D60, D90, D120, D180, D210, D240};

    state_e            r_state;
    logic [9:0]        r_clr_addr;
    logic [2:0]        r_rd_t, r_rd_b;
    logic [4:0]        r_rd_cnt;
    logic              r_wr_valid;
    logic [9:0]        r_wr_addr;
    logic [2:0]        r_wr_b;
    logic [4:0]        r_wr_idx;
    logic signed [7:0] r_x     [NUM_BANDS];
    logic [5:0]        r_ptr   [NUM_TEMPOS];
    logic signed [7:0] r_stage [NUM_CHANS];
    logic signed [7:0] r_out   [NUM_CHANS];
    logic              r_ready;

    logic [9:0]        w_rd_addr;
    logic [7:0]        w_rdata;
    logic signed [9:0] w_yd, w_x, w_sum;
    logic signed [7:0] w_y;
    logic              w_we;
    logic [9:0]        w_waddr;
    logic [7:0]        w_wdata;

    always_comb begin
        w_rd_addr = 10'(BANK_STRIDE * 32'(r_rd_b) + TEMPO_OFFSET[r_rd_t] + 32'(r_ptr[r_rd_t]));
        w_yd      = {{2{w_rdata[7]}}, w_rdata};
        w_x       = {{2{r_x[r_wr_b][7]}}, r_x[r_wr_b]};
        w_sum     = w_x + w_yd - (w_yd >>> ALPHA_SHIFT);
        w_y       = sat8(w_sum);
        if (r_state == StClear) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = 8'h00;
        end else begin
            w_we    = r_wr_valid;
            w_waddr = r_wr_addr;
            w_wdata = w_y;
        end
    end

    comb_delay_ram u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StClear;
            r_clr_addr <= '0;
            r_rd_t     <= '0;
            r_rd_b     <= '0;
            r_rd_cnt   <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_b     <= '0;
            r_wr_idx   <= '0;
            r_ready    <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) r_x[i] <= '0;
            for (int i = 0; i < NUM_TEMPOS; i++) r_ptr[i] <= '0;
            for (int i = 0; i < NUM_CHANS; i++) begin
                r_stage[i] <= '0;
                r_out[i]   <= '0;
            end
        end else begin
            r_ready    <= 1'b0;
            r_wr_valid <= 1'b0;
            unique case (r_state)
                StClear: begin
                    r_clr_addr <= r_clr_addr + 10'd1;
                    if (r_clr_addr == 10'(MEM_WORDS - 1)) r_state <= StIdle;
                end
                StIdle: begin
                    if (i_sample_valid) begin
                        r_x[0]   <= i_band0;
                        r_x[1]   <= i_band1;
                        r_x[2]   <= i_band2;
                        r_x[3]   <= i_band3;
                        r_x[4]   <= i_band4;
                        r_rd_t   <= '0;
                        r_rd_b   <= '0;
                        r_rd_cnt <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    // Issue read k while the write stage finishes channel k-1.
                    if (r_rd_cnt != 5'(NUM_CHANS)) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= w_rd_addr;
                        r_wr_b     <= r_rd_b;
                        r_wr_idx   <= r_rd_cnt;
                        r_rd_cnt   <= r_rd_cnt + 5'd1;
                        if (r_rd_b == 3'(NUM_BANDS - 1)) begin
                            r_rd_b <= '0;
                            r_rd_t <= (r_rd_t == 3'(NUM_TEMPOS - 1)) ? 3'd0 : r_rd_t + 3'd1;
                        end else begin
                            r_rd_b <= r_rd_b + 3'd1;
                        end
                    end
                    if (r_wr_valid) begin
                        r_stage[r_wr_idx] <= w_y;
                        if (r_wr_idx == 5'(NUM_CHANS - 1)) begin
                            // Last result bypasses staging so outputs and ready land in DONE.
                            for (int i = 0; i < NUM_CHANS - 1; i++) r_out[i] <= r_stage[i];
                            r_out[NUM_CHANS-1] <= w_y;
                            r_ready            <= 1'b1;
                            r_state            <= StDone;
                        end
                    end
                end
                StDone: begin
                    for (int i = 0; i < NUM_TEMPOS; i++) begin
                        r_ptr[i] <= (r_ptr[i] == 6'(DLY[i] - 1)) ? 6'd0 : r_ptr[i] + 6'd1;
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StClear;
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_overrun = i_sample_valid & ~i_reset & (r_state != StIdle);

    assign o_comb00 = r_out[0];  assign o_comb01 = r_out[5];  assign o_comb02 = r_out[10];
    assign o_comb03 = r_out[15]; assign o_comb04 = r_out[20]; assign o_comb05 = r_out[25];
    assign o_comb10 = r_out[1];  assign o_comb11 = r_out[6];  assign o_comb12 = r_out[11];
    assign o_comb13 = r_out[16]; assign o_comb14 = r_out[21]; assign o_comb15 = r_out[26];
    assign o_comb20 = r_out[2];  assign o_comb21 = r_out[7];  assign o_comb22 = r_out[12];
    assign o_comb23 = r_out[17]; assign o_comb24 = r_out[22]; assign o_comb25 = r_out[27];
    assign o_comb30 = r_out[3];  assign o_comb31 = r_out[8];  assign o_comb32 = r_out[13];
    assign o_comb33 = r_out[18]; assign o_comb34 = r_out[23]; assign o_comb35 = r_out[28];
    assign o_comb40 = r_out[4];  assign o_comb41 = r_out[9];  assign o_comb42 = r_out[14];
    assign o_comb43 = r_out[19]; assign o_comb44 = r_out[24]; assign o_comb45 = r_out[29];

endmodule

// File: tb/tb_comb_bank.sv
// Self-checking bench for comb_bank: per-frame history model plus literal spot checks.
module tb_comb_bank;

    localparam int ALPHA = 2;
    localparam int DT [6] = '{50, 33, 25, 17, 14, 12};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              sample_valid = 1'b0;
    logic signed [7:0] band [5];
    logic signed [7:0] comb [5][6];
    logic              ready, overrun;

    comb_bank dut (
        .i_clk(clk), .i_reset(reset), .i_sample_valid(sample_valid),
        .i_band0(band[0]), .i_band1(band[1]), .i_band2(band[2]),
        .i_band3(band[3]), .i_band4(band[4]),
        .o_comb00(comb[0][0]), .o_comb01(comb[0][1]), .o_comb02(comb[0][2]),
        .o_comb03(comb[0][3]), .o_comb04(comb[0][4]), .o_comb05(comb[0][5]),
        .o_comb10(comb[1][0]), .o_comb11(comb[1][1]), .o_comb12(comb[1][2]),
        .o_comb13(comb[1][3]), .o_comb14(comb[1][4]), .o_comb15(comb[1][5]),
        .o_comb20(comb[2][0]), .o_comb21(comb[2][1]), .o_comb22(comb[2][2]),
        .o_comb23(comb[2][3]), .o_comb24(comb[2][4]), .o_comb25(comb[2][5]),
        .o_comb30(comb[3][0]), .o_comb31(comb[3][1]), .o_comb32(comb[3][2]),
        .o_comb33(comb[3][3]), .o_comb34(comb[3][4]), .o_comb35(comb[3][5]),
        .o_comb40(comb[4][0]), .o_comb41(comb[4][1]), .o_comb42(comb[4][2]),
        .o_comb43(comb[4][3]), .o_comb44(comb[4][4]), .o_comb45(comb[4][5]),
        .o_ready(ready), .o_overrun(overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: full output history per channel, indexed by frame number since reset.
    int hist [5][6][128];
    int frame_n = 0;
    int pend [5][6];
    int held [5][6];
    int exp_ready_cyc = -1;
    int idle_from = 0;
    bit exp_ovr = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_frame(input int x [5]);
        int yd;
        for (int b = 0; b < 5; b++) begin
            for (int t = 0; t < 6; t++) begin
                yd = (frame_n >= DT[t]) ? hist[b][t][frame_n - DT[t]] : 0;
                pend[b][t] = sat(x[b] + yd - (yd >>> ALPHA));
                hist[b][t][frame_n] = pend[b][t];
            end
        end
        frame_n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        exp_ovr = 1'b0;
        exp_ready_cyc = -1;
        repeat (3) tick();
        reset = 1'b0;
        idle_from = cyc + 755;
        frame_n = 0;
    endtask

    task automatic pulse(input int x0, input int x1, input int x2, input int x3, input int x4);
        int x [5];
        x = '{x0, x1, x2, x3, x4};
        for (int i = 0; i < 5; i++) band[i] = x[i][7:0];
        sample_valid = 1'b1;
        if (cyc >= idle_from) begin
            model_frame(x);
            exp_ready_cyc = cyc + 32;
            idle_from = cyc + 33;
            exp_ovr = 1'b0;
        end else begin
            exp_ovr = 1'b1;
        end
        tick();
        sample_valid = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic frame(input int x0, input int x1, input int x2, input int x3, input int x4);
        while (cyc < idle_from) tick();
        pulse(x0, x1, x2, x3, x4);
    endtask

    task automatic wait_ready();
        while (cyc <= exp_ready_cyc) tick();
    endtask

    // Every cycle out of reset: ready/overrun timing and the held output set.
    always @(negedge clk) begin
        int nbad, fb, ft;
        if (reset) begin
            for (int b = 0; b < 5; b++) for (int t = 0; t < 6; t++) held[b][t] = 0;
        end else begin
            if (cyc == exp_ready_cyc) held = pend;
            check("ready", int'(ready), (cyc == exp_ready_cyc) ? 1 : 0);
            check("overrun", int'(overrun), int'(exp_ovr));
            nbad = 0; fb = 0; ft = 0;
            for (int b = 0; b < 5; b++) begin
                for (int t = 0; t < 6; t++) begin
                    if (int'(comb[b][t]) != held[b][t]) begin
                        if (nbad == 0) begin fb = b; ft = t; end
                        nbad++;
                    end
                end
            end
            n_tests++;
            if (nbad != 0) begin
                n_fail++;
                $display("FAIL outputs at cycle %0d: comb%0d%0d got %0d, want %0d (%0d wrong)",
                         cyc, fb, ft, int'(comb[fb][ft]), held[fb][ft], nbad);
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) band[i] = '0;

        // Reset, CLEAR length and drops during CLEAR.
        do_reset();
        check("rst_comb20", int'(comb[2][0]), 0);
        check("rst_ready", int'(ready), 0);
        while (cyc < idle_from - 755 + 100) tick();
        pulse(1, 2, 3, 4, 5);
        while (cyc < idle_from - 1) tick();
        pulse(9, 9, 9, 9, 9);

        // Impulse on band 2.
        frame(0, 0, 64, 0, 0);
        wait_ready();
        for (int t = 0; t < 6; t++) begin
            check("imp_f0_comb2x", int'(comb[2][t]), 64);
            check("imp_f0_model", pend[2][t], 64);
        end
        check("imp_f0_comb10", int'(comb[1][0]), 0);
        for (int n = 1; n <= 50; n++) begin
            frame(0, 0, 0, 0, 0);
            wait_ready();
            if (n == 12) begin
                check("imp_f12_comb25", int'(comb[2][5]), 48);
                check("imp_f12_model", pend[2][5], 48);
            end
            if (n == 25) begin
                check("imp_f25_comb22", int'(comb[2][2]), 48);
                check("imp_f25_model", pend[2][2], 48);
            end
            if (n == 50) begin
                check("imp_f50_comb22", int'(comb[2][2]), 36);
                check("imp_f50_model", pend[2][2], 36);
            end
        end

        // Second strobe 5 cycles into a frame is dropped.
        frame(10, -20, 30, -40, 50);
        repeat (4) tick();
        pulse(1, 1, 1, 1, 1);
        wait_ready();
        check("ovr_comb00", int'(comb[0][0]), 10);
        check("ovr_comb30", int'(comb[3][0]), -40);
        check("ovr_comb45", int'(comb[4][5]), 50);

        // Reset at RUN cycle 10, then frame 0 of the impulse again.
        frame(5, 5, 5, 5, 5);
        while (cyc < exp_ready_cyc - 22) tick();
        do_reset();
        check("midrst_comb00", int'(comb[0][0]), 0);
        check("midrst_comb40", int'(comb[4][0]), 0);
        while (cyc < idle_from - 1) tick();
        pulse(7, 7, 7, 7, 7);
        frame(0, 0, 64, 0, 0);
        wait_ready();
        check("midrst_comb22", int'(comb[2][2]), 64);
        check("midrst_comb25", int'(comb[2][5]), 64);
        check("midrst_comb00b", int'(comb[0][0]), 0);

        // Saturation high.
        for (int n = 0; n < 60; n++) frame(127, 127, 127, 127, 127);
        wait_ready();
        for (int b = 0; b < 5; b++) for (int t = 0; t < 6; t++)
            check("sat_hi", int'(comb[b][t]), 127);

        // Saturation low from a clean memory.
        do_reset();
        for (int n = 0; n < 60; n++) frame(-128, -128, -128, -128, -128);
        wait_ready();
        for (int b = 0; b < 5; b++) for (int t = 0; t < 6; t++)
            check("sat_lo", int'(comb[b][t]), -128);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_bank.md
# comb_bank

Resonant comb-filter bank feeding the tempo peak picker. Takes five signed 8-bit band-envelope samples per frame and runs each through six feedback comb filters, one tuned to each candidate tempo (60/90/120/180/210/240 BPM). Presents all 30 filter outputs as `comb<band><tempo>` with a one-cycle `ready` strobe, matching the picker's input port set. Processing is time-multiplexed over one shared delay memory.

## Interface
- `ALPHA_SHIFT`, 2: feedback coefficient is alpha = 1 − 2^−ALPHA_SHIFT (default 0.75).
- `D60, D90, D120, D180, D210, D240`, 50, 33, 25, 17, 14, 12: delay of each tempo's comb, in frames. Defaults assume a 50 Hz envelope frame rate.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `sample_valid` in 1: one-cycle strobe; `band0..band4` are valid in this cycle.
- `band0..band4` in 8 each, signed: envelope samples, one per band.
- `comb00..comb45` out 8 each, signed: filter outputs. First digit is band 0–4; second digit is tempo index 0–5, mapping to 60, 90, 120, 180, 210, 240 BPM.
- `ready` out 1: one-cycle pulse; all 30 outputs are fresh in this cycle.
- `overrun` out 1: one-cycle pulse when a `sample_valid` is dropped.

## Operation
- Per channel (band b, tempo t):
  - yd = y[n−D_t], read from memory.
  - y = sat8(x_b + yd − (yd >>> ALPHA_SHIFT)).
  - Arithmetic is 10-bit signed. Saturate to [−128, 127].
  - Write y back at the same address.
- Memory holds 5 × 151 = 755 bytes.
  - Per-band region base is b × 151.
  - Tempo offsets within a region: 0, 50, 83, 108, 125, 139.
  - Address = b × 151 + off_t + ptr_t.
- Pointers: six ring pointers `ptr_t`, each in 0..D_t−1. All six advance by 1 after each completed frame. Each wraps from D_t−1 to 0.
- FSM states:
  - CLEAR: entered on reset. Writes zero to all 755 words, one per cycle. Goes to IDLE after address 754.
  - IDLE: on `sample_valid`, latch `band0..band4` and go to RUN.
  - RUN: iterate 30 channels in order t-major, b-minor (t=0 b=0..4, then t=1 …). Read and compute/write are pipelined: read channel k while writing channel k−1. Results go into a 30-entry staging register set. After the last write, go to DONE.
  - DONE: copy staging to `comb*`, pulse `ready`, advance pointers, go to IDLE.
- `sample_valid` in CLEAR, RUN or DONE: sample is dropped and `overrun` pulses in that cycle. Channel state is unchanged.
- Reset values:
  - `comb*` = 0, `ready` = 0, `overrun` = 0.
  - All `ptr_t` = 0, staging = 0, state = CLEAR.
- Reset mid-RUN: the frame is abandoned, no `ready`, and the memory is re-cleared.

## Timing
- Cycle 0: `sample_valid` in IDLE.
- Cycles 1–30: reads.
- Cycles 2–31: writes.
- Cycle 32: DONE. `ready` = 1 and `comb*` take new values in the same cycle. `comb*` then hold until the next `ready`.
- Cycle 33: IDLE. Earliest accepted `sample_valid` is cycle 33, giving a minimum frame spacing of 33 cycles.
- After reset deassertion, CLEAR lasts 755 cycles. The first accepted `sample_valid` is 755 cycles after the first cycle with `reset` low.
- Memory read latency is one cycle, registered output.
- Read and write to the same address never coincide. Within a frame every channel address is distinct.

## Structure
- Shared package `beat_pkg`:
  - NUM_BANDS = 5, NUM_TEMPOS = 6.
  - Tempo BPM constants {60, 90, 120, 180, 210, 240}.
  - Default delay constants, per-tempo offset table, BANK_STRIDE = 151.
  - `sat8` function.
  - FSM state enum.
- Submodule `comb_delay_ram`: simple dual-port 1024 × 8 with synchronous read, one write port and one read port.
- `comb_bank` holds the FSM, channel counters, pointers, address generation, datapath and staging/output registers.

## Test plan
- **Reset/clear:** assert `reset` 3 cycles, release. Required: all outputs 0; 755-cycle CLEAR; a `sample_valid` at CLEAR cycle 100 gives `overrun` = 1 and no `ready`.
- **Impulse:** band2 = 64 in frame 0, zeros afterward, all other bands 0.
  - Frame 0: `comb20..comb25` = 64.
  - Frame 25: `comb22` = 48. Frame 50: `comb22` = 36.
  - Frame 12: `comb25` = 48.
  - All band0/1/3/4 outputs stay 0.
- **Latency:** `sample_valid` at cycle T in IDLE → `ready` high exactly at T+32 for one cycle, and `comb*` stable through the following RUN.
- **Saturation:** constant 127 on all bands for 60 frames → every output 127, no wrap. Constant −128 → every output −128.
- **Overrun:** second `sample_valid` 5 cycles after the first → `overrun` pulse at that cycle, and exactly one `ready`. Results match the single-sample golden model.
- **Reset mid-RUN:** `reset` at RUN cycle 10 → no `ready`, outputs 0, CLEAR repeats. Then the impulse test reproduces frame-0 values.
